// File: rtl/prbg_detect_logger_if.sv
// Readout port of the detection logger: FWFT head data plus pop request.
interface prbg_detect_logger_if #(
  parameter int TS_W = 8
);
  logic            rd_en;
  logic            rd_valid;
  logic [TS_W-1:0] rd_time;
  logic [2:0]      rd_sym;

  modport master (output rd_en, input rd_valid, input rd_time, input rd_sym);
  modport slave  (input rd_en, output rd_valid, output rd_time, output rd_sym);
endinterface

// File: rtl/prbg_detect_logger.sv
// Timestamps rising edges of the PRBG detector output and queues (time, symbol)
// pairs in a first-word-fall-through FIFO, with count, gap and overflow status.
module prbg_detect_logger #(
  parameter int TS_W  = 8,
  parameter int CNT_W = 6,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   en,
  input  logic                   detect_in,
  input  logic [2:0]             shift_in,
  prbg_detect_logger_if.slave    rd,
  output logic [CNT_W-1:0]       det_count,
  output logic [CNT_W-1:0]       last_gap,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);

  logic [TS_W-1:0]  ts_r;
  logic             prev_det_r;
  logic [CNT_W-1:0] gap_cnt_r;
  logic [CNT_W-1:0] det_count_r;
  logic [CNT_W-1:0] last_gap_r;
  logic             seen_first_r;
  logic             overflow_r;
  logic             rd_valid_r;
  logic [LW-1:0]    level_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [TS_W-1:0]  mem_time_r [DEPTH];
  logic [2:0]       mem_sym_r  [DEPTH];

  logic             event_s;
  logic             pop_s;
  logic             full_s;
  logic             push_s;
  logic             drop_s;
  logic [LW-1:0]    level_nxt_s;

  // Event detection and FIFO push/pop arbitration; a full FIFO still accepts a push alongside a pop.
  always_comb begin
    event_s     = en & detect_in & ~prev_det_r;
    pop_s       = rd.rd_en & rd_valid_r;
    full_s      = (level_r == LVL_FULL);
    push_s      = event_s & (~full_s | pop_s);
    drop_s      = event_s & full_s & ~pop_s;
    level_nxt_s = level_r;
    if (push_s && !pop_s) begin
      level_nxt_s = level_r + LW'(1);
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - LW'(1);
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Head entry falls straight through from storage; zeros while empty.
  always_comb begin
    rd.rd_valid = rd_valid_r;
    if (rd_valid_r) begin
      rd.rd_time = mem_time_r[rd_ptr_r];
      rd.rd_sym  = mem_sym_r[rd_ptr_r];
    end else begin
      rd.rd_time = {TS_W{1'b0}};
      rd.rd_sym  = 3'b000;
    end
  end

  // Timestamp, edge history, counters and FIFO control state.
  always_ff @(posedge clk) begin
    if (res) begin
      ts_r         <= {TS_W{1'b0}};
      prev_det_r   <= 1'b0;
      gap_cnt_r    <= {CNT_W{1'b0}};
      det_count_r  <= {CNT_W{1'b0}};
      last_gap_r   <= {CNT_W{1'b0}};
      seen_first_r <= 1'b0;
      overflow_r   <= 1'b0;
      rd_valid_r   <= 1'b0;
      level_r      <= {LW{1'b0}};
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
    end else begin
      ts_r       <= ts_r + TS_W'(1);
      prev_det_r <= detect_in;
      if (event_s) begin
        gap_cnt_r    <= CNT_W'(1);
        seen_first_r <= 1'b1;
        if (seen_first_r) begin
          last_gap_r <= gap_cnt_r;
        end
        if (det_count_r != CNT_MAX) begin
          det_count_r <= det_count_r + CNT_W'(1);
        end
      end else if (gap_cnt_r != CNT_MAX) begin
        gap_cnt_r <= gap_cnt_r + CNT_W'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r    <= level_nxt_s;
      rd_valid_r <= (level_nxt_s != {LW{1'b0}});
    end
  end

  // FIFO storage; contents behind the pointers are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_time_r[wr_ptr_r] <= ts_r;
      mem_sym_r[wr_ptr_r]  <= shift_in;
    end
  end

  assign det_count  = det_count_r;
  assign last_gap   = last_gap_r;
  assign fifo_level = level_r;
  assign overflow   = overflow_r;
endmodule

// File: tb/tb_prbg_detect_logger.sv
// Bench for prbg_detect_logger: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_prbg_detect_logger;
  localparam int TS_W  = 8;
  localparam int CNT_W = 6;
  localparam int DEPTH = 4;
  localparam int SAT   = 63;

  logic clk = 1'b0;
  logic res, en, detect_in;
  logic [2:0] shift_in;
  logic [CNT_W-1:0] det_count, last_gap;
  logic [$clog2(DEPTH):0] fifo_level;
  logic overflow;

  int n_cmp = 0;
  int n_bad = 0;

  prbg_detect_logger_if #(.TS_W(TS_W)) rd_if ();

  prbg_detect_logger #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .res(res), .en(en), .detect_in(detect_in), .shift_in(shift_in),
    .rd(rd_if.slave), .det_count(det_count), .last_gap(last_gap),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  int q_t[$];
  int q_s[$];
  int m_ts, m_cnt, m_last_gap, m_cyc, m_last_cyc;
  bit m_prev, m_seen, m_ovf;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (res) begin
      q_t.delete(); q_s.delete();
      m_ts = 0; m_prev = 0; m_cnt = 0; m_last_gap = 0; m_seen = 0; m_ovf = 0;
      m_cyc = 0; m_last_cyc = 0;
    end else begin
      bit ev;
      ev = en && detect_in && !m_prev;
      if (rd_if.rd_en && q_t.size() > 0) begin
        void'(q_t.pop_front()); void'(q_s.pop_front());
      end
      if (ev) begin
        if (q_t.size() < DEPTH) begin
          q_t.push_back(m_ts); q_s.push_back(int'(shift_in));
        end else begin
          m_ovf = 1;
        end
        if (m_seen) m_last_gap = (m_cyc - m_last_cyc > SAT) ? SAT : m_cyc - m_last_cyc;
        m_seen = 1;
        m_last_cyc = m_cyc;
        m_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
      end
      m_prev = detect_in;
      m_ts = (m_ts + 1) % (1 << TS_W);
      m_cyc++;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    int sz;
    sz = q_t.size();
    chk("rd_valid", int'(rd_if.rd_valid), (sz > 0) ? 1 : 0);
    chk("rd_time", int'(rd_if.rd_time), (sz > 0) ? q_t[0] : 0);
    chk("rd_sym", int'(rd_if.rd_sym), (sz > 0) ? q_s[0] : 0);
    chk("det_count", int'(det_count), m_cnt);
    chk("last_gap", int'(last_gap), m_last_gap);
    chk("fifo_level", int'(fifo_level), sz);
    chk("overflow", int'(overflow), int'(m_ovf));
  end

  task automatic do_reset();
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] sym);
    detect_in = 1'b1; shift_in = sym;
    @(negedge clk);
    detect_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_expect(input string nm, input int t);
    chk(nm, int'(rd_if.rd_time), t);
    rd_if.rd_en = 1'b1;
    @(negedge clk);
    rd_if.rd_en = 1'b0;
  endtask

  task automatic wait_ts(input int t);
    int n = 0;
    while (m_ts != t && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (m_ts != t) chk("wait_ts_timeout", m_ts, t);
  endtask

  initial begin
    res = 1'b1; en = 1'b0; detect_in = 1'b0; shift_in = 3'd0; rd_if.rd_en = 1'b0;
    @(negedge clk); @(negedge clk);
    res = 1'b0; en = 1'b1;
    chk("rst_valid", int'(rd_if.rd_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    repeat (20) @(negedge clk);
    chk("model_ts20", m_ts, 20);
    chk("idle_count", int'(det_count), 0);
    chk("idle_ovf", int'(overflow), 0);

    // Single 3-cycle pulse at ts=10
    do_reset();
    wait_ts(10);
    detect_in = 1'b1; shift_in = 3'b101;
    repeat (3) @(negedge clk);
    detect_in = 1'b0;
    @(negedge clk);
    chk("single_time", int'(rd_if.rd_time), 10);
    chk("single_sym", int'(rd_if.rd_sym), 5);
    chk("single_count", int'(det_count), 1);
    chk("single_level", int'(fifo_level), 1);
    pop_expect("single_pop", 10);
    chk("single_empty", int'(rd_if.rd_valid), 0);

    // Gap of 7 between edges at ts 10 and 17
    do_reset();
    wait_ts(10);
    pulse(3'd1);
    wait_ts(17);
    pulse(3'd2);
    chk("gap_last", int'(last_gap), 7);
    chk("gap_count", int'(det_count), 2);
    pop_expect("gap_first", 10);
    pop_expect("gap_second", 17);

    // Overflow: six edges into a 4-deep FIFO
    do_reset();
    for (int i = 0; i < 6; i++) pulse(3'(i));
    chk("ovf_level", int'(fifo_level), 4);
    chk("ovf_count", int'(det_count), 6);
    chk("ovf_flag", int'(overflow), 1);
    for (int i = 0; i < 4; i++) pop_expect("ovf_drain", 2 * i);
    chk("ovf_sticky", int'(overflow), 1);

    // Full FIFO with push and pop on the same edge
    do_reset();
    for (int i = 0; i < 4; i++) pulse(3'(i));
    detect_in = 1'b1; shift_in = 3'd7; rd_if.rd_en = 1'b1;
    @(negedge clk);
    detect_in = 1'b0; rd_if.rd_en = 1'b0;
    chk("fullpp_level", int'(fifo_level), 4);
    chk("fullpp_ovf", int'(overflow), 0);
    for (int i = 1; i < 5; i++) pop_expect("fullpp_order", 2 * i);

    // Edge while disabled is lost
    do_reset();
    en = 1'b0; detect_in = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    detect_in = 1'b0;
    @(negedge clk);
    chk("en_count", int'(det_count), 0);
    chk("en_level", int'(fifo_level), 0);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) pulse(3'(i));
    chk("rstq_level_pre", int'(fifo_level), 3);
    do_reset();
    chk("rstq_level", int'(fifo_level), 0);
    chk("rstq_valid", int'(rd_if.rd_valid), 0);
    chk("rstq_count", int'(det_count), 0);

    // Timestamp wrap 255 -> 0
    do_reset();
    wait_ts(254);
    pulse(3'd3);
    pulse(3'd4);
    chk("wrap_gap", int'(last_gap), 2);
    pop_expect("wrap_254", 254);
    pop_expect("wrap_0", 0);

    // Randomized traffic with quiet stretches for gap saturation
    for (int i = 0; i < 3000; i++) begin
      res         = ($urandom_range(0, 499) == 0);
      en          = ($urandom_range(0, 9) != 0);
      detect_in   = ((i % 400) < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      shift_in    = 3'($urandom_range(0, 7));
      rd_if.rd_en = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    res = 1'b0; detect_in = 1'b0; rd_if.rd_en = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
